// File: rtl/pool_pkg.sv
// Shared types and elaboration-time helpers for the max-pool window address generator.
package pool_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pool_state_e;

  // Ceiling log2, never below 1 so single-entry counters still get a bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 1) ? v - 1 : 0;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // Pooled output extent (floor division); a zero stride is caught by the top-level check.
  function automatic int unsigned out_dim(input int unsigned img, input int unsigned k,
                                          input int unsigned s);
    if (s == 0 || k > img) return 1;
    return (img - k) / s + 1;
  endfunction

  // Derived constants for the default geometry (26x26x3, 2x2 window, stride 2).
  localparam int unsigned DEF_IMG_W    = 26;
  localparam int unsigned DEF_IMG_H    = 26;
  localparam int unsigned DEF_CHANNELS = 3;
  localparam int unsigned DEF_POOL_K   = 2;
  localparam int unsigned DEF_STRIDE   = 2;
  localparam int unsigned OUT_W        = out_dim(DEF_IMG_W, DEF_POOL_K, DEF_STRIDE);
  localparam int unsigned OUT_H        = out_dim(DEF_IMG_H, DEF_POOL_K, DEF_STRIDE);
  localparam int unsigned N_WIN        = DEF_CHANNELS * OUT_W * OUT_H;
  localparam int unsigned PLANE        = DEF_IMG_W * DEF_IMG_H;
  localparam int unsigned ROW_STEP     = DEF_STRIDE * DEF_IMG_W;

endpackage

// File: rtl/pool_axis_counter.sv
// Wrap counter with a companion address pointer that advances by a fixed step.
module pool_axis_counter #(
  parameter int unsigned LIMIT = 2,
  parameter int unsigned STEP  = 1,
  parameter int unsigned CNT_W = 1,
  parameter int unsigned PTR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic [PTR_W-1:0] ptr,
  output logic             wrap,
  output logic             carry
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  assign wrap  = (cnt_q == CNT_W'(LIMIT - 1));
  assign carry = en && wrap;
  assign cnt   = cnt_q;
  assign ptr   = ptr_q;

  // Next count/pointer: clear, hold, step, or wrap back to zero.
  always_comb begin
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    if (clr) begin
      cnt_d = '0;
      ptr_d = '0;
    end else if (en) begin
      if (wrap) begin
        cnt_d = '0;
        ptr_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        ptr_d = ptr_q + PTR_W'(STEP);
      end
    end
  end

  // Count and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ptr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/pool_window_addr_gen.sv
// Max-pool window address generator: emits all POOL_K*POOL_K read addresses of
// one window per accepted transaction plus the pooled write address.
module pool_window_addr_gen
  import pool_pkg::*;
#(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned OUT_ADDR_W = 9,
  parameter int unsigned IMG_W      = 26,
  parameter int unsigned IMG_H      = 26,
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned POOL_K     = 2,
  parameter int unsigned STRIDE     = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             loop_en,
  output logic                             win_valid,
  input  logic                             win_ready,
  output logic [POOL_K*POOL_K*ADDR_W-1:0]  rd_addr,
  output logic [OUT_ADDR_W-1:0]            wr_addr,
  output logic [clog2(CHANNELS)-1:0]       chan,
  output logic                             last,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned O_W   = out_dim(IMG_W, POOL_K, STRIDE);
  localparam int unsigned O_H   = out_dim(IMG_H, POOL_K, STRIDE);
  localparam int unsigned PLN   = IMG_W * IMG_H;
  localparam int unsigned RSTEP = STRIDE * IMG_W;
  localparam int unsigned COL_W = clog2(O_W);
  localparam int unsigned ROW_W = clog2(O_H);
  localparam int unsigned CH_W  = clog2(CHANNELS);

  if (POOL_K > IMG_W || POOL_K > IMG_H || STRIDE == 0 ||
      longint'(CHANNELS) * longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_W) ||
      longint'(CHANNELS) * longint'(O_W) * longint'(O_H) > (longint'(1) << OUT_ADDR_W))
  begin : g_cfg_err
    $error("pool_window_addr_gen: illegal geometry or address width");
  end

  pool_state_e state_q, state_d;
  logic [OUT_ADDR_W-1:0] wr_q, wr_d;
  logic load, accept;

  logic [COL_W-1:0]  ocol;
  logic [ROW_W-1:0]  orow;
  logic [CH_W-1:0]   ch;
  logic [ADDR_W-1:0] col_ptr, row_ptr, ch_ptr, base;
  logic col_wrap, row_wrap, ch_wrap;
  logic col_carry, row_carry, ch_carry;
  logic unused_cnt;

  assign win_valid = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign accept    = win_valid && win_ready;
  assign last      = win_valid && col_wrap && row_wrap && ch_wrap;
  assign wr_addr   = wr_q;
  assign chan      = ch;
  assign unused_cnt = ^{ocol, orow};

  // Column, row and channel counters chained by carry; ch_carry marks the final accept.
  pool_axis_counter #(.LIMIT(O_W), .STEP(STRIDE), .CNT_W(COL_W), .PTR_W(ADDR_W)) u_col (
    .clk(clk), .rst_n(rst), .clr(load), .en(accept),
    .cnt(ocol), .ptr(col_ptr), .wrap(col_wrap), .carry(col_carry)
  );

  pool_axis_counter #(.LIMIT(O_H), .STEP(RSTEP), .CNT_W(ROW_W), .PTR_W(ADDR_W)) u_row (
    .clk(clk), .rst_n(rst), .clr(load), .en(col_carry),
    .cnt(orow), .ptr(row_ptr), .wrap(row_wrap), .carry(row_carry)
  );

  pool_axis_counter #(.LIMIT(CHANNELS), .STEP(PLN), .CNT_W(CH_W), .PTR_W(ADDR_W)) u_ch (
    .clk(clk), .rst_n(rst), .clr(load), .en(row_carry),
    .cnt(ch), .ptr(ch_ptr), .wrap(ch_wrap), .carry(ch_carry)
  );

  assign base = ch_ptr + row_ptr + col_ptr;

  // Window element (i,j) sits at a constant offset from the window base.
  always_comb begin
    rd_addr = '0;
    for (int unsigned i = 0; i < POOL_K; i++) begin
      for (int unsigned j = 0; j < POOL_K; j++) begin
        rd_addr[(i*POOL_K+j)*ADDR_W +: ADDR_W] = base + ADDR_W'(i*IMG_W + j);
      end
    end
  end

  // Frame control: start loads window 0, final accept ends the frame, DONE may loop.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        load    = 1'b1;
      end
      RUN:  if (ch_carry) state_d = DONE;
      DONE: state_d = loop_en ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pooled output index: one step per accepted window, back to 0 after the last.
  always_comb begin
    wr_d = wr_q;
    if (load || ch_carry) wr_d = '0;
    else if (accept)      wr_d = wr_q + OUT_ADDR_W'(1);
  end

  // State and write-index registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
    end
  end

endmodule

// File: doc/pool_window_addr_gen.md
Name: pool_window_addr_gen

Overview:
- Parametrised max-pool read/write address generator: walks a channel-major convolution-result memory and emits all POOL_K*POOL_K read addresses of one pooling window per transaction, together with the matching output (pooled) write address.
- Sits between the conv result memory and the max-pool comparator tree.
- Adds start/done control, a valid/ready handshake, configurable window, stride and image geometry, and optional continuous looping.

Parameters:
- ADDR_W, 11, width of read addresses; must satisfy CHANNELS*IMG_W*IMG_H <= 2**ADDR_W.
- OUT_ADDR_W, 9, width of the pooled output address; must satisfy CHANNELS*OUT_W*OUT_H <= 2**OUT_ADDR_W.
- IMG_W, 26, input feature-map width in pixels.
- IMG_H, 26, input feature-map height in pixels.
- CHANNELS, 3, number of feature maps, stored contiguously.
- POOL_K, 2, window side length; window holds POOL_K*POOL_K elements.
- STRIDE, 2, window step in both directions.
- Derived: OUT_W = (IMG_W-POOL_K)/STRIDE+1 and OUT_H = (IMG_H-POOL_K)/STRIDE+1, both using floor division. Defaults give 13x13x3 = 507 windows.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-low reset.
- start, in, 1, single-cycle request to begin a frame; ignored unless IDLE.
- loop_en, in, 1, when 1 the frame restarts automatically after done.
- win_valid, out, 1, current window addresses are valid.
- win_ready, in, 1, consumer accepts the window when win_valid && win_ready.
- rd_addr, out, POOL_K*POOL_K*ADDR_W, flattened read addresses. Element e = i*POOL_K+j (row i, col j) occupies bits [e*ADDR_W +: ADDR_W].
- wr_addr, out, OUT_ADDR_W, linear pooled-output index of the current window.
- chan, out, clog2(CHANNELS), current channel index.
- last, out, 1, high with win_valid on the final window of the frame.
- busy, out, 1, high in RUN.
- done, out, 1, one-cycle pulse after the final window is accepted.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE immediately, including mid-frame.
  - win_valid, last, busy and done are 0.
  - The base, row and channel registers, wr_addr, chan and all col/row counters are 0.
  - rd_addr therefore shows the window-0 pattern but is not valid.
- Addressing:
  - Registered pointer base = ch*IMG_W*IMG_H + orow*STRIDE*IMG_W + ocol*STRIDE.
  - rd_addr element (i,j) = base + i*IMG_W + j, computed from registers with constant offsets; no multipliers in the datapath.
  - Pointers update incrementally:
    - column step: base += STRIDE.
    - row step: row_base += STRIDE*IMG_W.
    - channel step: ch_base += IMG_W*IMG_H.
  - Traversal order: ocol fastest, then orow, then channel.
  - wr_addr increments by 1 per accepted window, from 0 to CHANNELS*OUT_W*OUT_H-1.
  - Columns IMG_W-((IMG_W-POOL_K)%STRIDE) .. IMG_W-1 and the equivalent rows are never addressed.
- FSM states:
  - IDLE: start=1 loads window 0 and goes to RUN. win_valid rises on the next edge, so latency from start is 1 cycle.
  - RUN: win_valid=1. Outputs hold stable while win_valid && !win_ready. On an accept, the pointers advance and win_valid stays 1, giving one window per cycle under continuous ready. An accept with last=1 goes to DONE; win_valid drops on that edge.
  - DONE: done=1 for exactly 1 cycle, with counters already reset to window 0. Next state is RUN if loop_en=1 (win_valid 1 cycle after done, no bubble beyond DONE), otherwise IDLE.
- start while in RUN or DONE is ignored; there is no queueing.
- loop_en is sampled only in DONE.
- last = (ocol==OUT_W-1) && (orow==OUT_H-1) && (ch==CHANNELS-1).
- Degenerate geometry: CHANNELS=1 or OUT_W=1 must work, with wrap on every accept of that dimension.
- Elaboration error if POOL_K>IMG_W, POOL_K>IMG_H, STRIDE==0, or any ADDR_W/OUT_ADDR_W bound is violated.

Decomposition:
- Shared package pool_pkg holds:
  - function clog2.
  - Derived constants OUT_W, OUT_H, N_WIN, PLANE = IMG_W*IMG_H, ROW_STEP = STRIDE*IMG_W.
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- One sub-module, pool_axis_counter: a reusable wrap counter with limit and step parameters that outputs wrap and carry. It is instantiated three times (column, row, channel) and chained via carry.

Test Plan:
- Defaults, start pulse, win_ready=1 constantly:
  - First window rd_addr={0,1,26,27}, wr_addr=0.
  - Second window {2,3,28,29}.
  - 507 windows in 507 consecutive cycles, then done one cycle later.
- Row and channel wrap:
  - Window 13 gives {52,53,78,79}, orow=1.
  - Window 169 gives {676,677,702,703}, chan=1.
  - Window 506 gives {2000,2001,2026,2027} with last=1, wr_addr=506.
- Backpressure: toggle win_ready randomly → each window is held stable until accepted, no window is skipped or duplicated, and the total accepted count is 507.
- Reset at window 200 (rst low for 1 cycle, asynchronously mid-cycle) → win_valid=0 immediately, state IDLE. The next start restarts at {0,1,26,27}.
- loop_en=1 → after done, window 0 reappears with win_valid 1 cycle later. A start pulse during RUN has no effect on the sequence.
- Non-default geometry: POOL_K=3, STRIDE=1, IMG_W=IMG_H=5, CHANNELS=1.
  - First window {0,1,2,5,6,7,10,11,12}.
  - 9 windows total; last window base=12 gives {12,13,14,17,18,19,22,23,24}.
